// File: rtl/mlp_seq_pkg.sv
// Shared types and width helpers for the sequential MLP trainer.
package mlp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FWD_H, S_FWD_O, S_LOSS, S_BWD_H, S_BWD_O, S_DONE
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Headroom for summing n_terms products without overflow.
  function automatic int acc_w(input int p_w, input int n_terms);
    return p_w + $clog2(n_terms) + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Signed multiply-accumulate: clr restarts the sum, en=0 holds it; sum_o is the next value.
module mlp_mac
  import mlp_seq_pkg::*;
#(
  parameter int A_W   = 19,
  parameter int B_W   = 13,
  parameter int ACC_W = 36
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] sum_o
);
  localparam int PROD_W = prod_w(A_W, B_W);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod  = PROD_W'(a_i) * PROD_W'(b_i);
  assign base  = clr_i ? '0 : acc_q;
  assign sum_o = base + ACC_W'(prod);

  always_ff @(posedge clk_i) begin
    if (rst_i)     acc_q <= '0;
    else if (en_i) acc_q <= sum_o;
  end

endmodule

// File: rtl/mlp_train_seq.sv
// N_IN-N_HID-1 ReLU perceptron with on-chip weights and one time-shared MAC (inference or SGD step).
// Define MLP_TRAIN_SEQ_SAT_EN to saturate updated weights instead of two's-complement wrapping.
module mlp_train_seq
  import mlp_seq_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int N_HID    = 2,
  parameter int X_W      = 4,
  parameter int W_W      = 8,
  parameter int H_W      = 10,
  parameter int OUT_W    = 19,
  parameter int LR_SHIFT = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [N_IN*X_W-1:0]                  x_i,
  input  logic signed [OUT_W-1:0]              target_i,
  input  logic                                 train_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic signed [OUT_W-1:0]              y_o,
  output logic signed [OUT_W-1:0]              err_o,
  input  logic                                 wld_valid_i,
  input  logic [$clog2(N_HID*N_IN+N_HID)-1:0]  wld_addr_i,
  input  logic signed [W_W-1:0]                wld_data_i,
  output logic                                 busy_o,
  output logic [15:0]                          step_cnt_o
);
  localparam int NW     = N_HID*N_IN + N_HID;
  localparam int VBASE  = N_HID*N_IN;
  localparam int AW     = $clog2(NW);
  localparam int JW     = idx_w(N_HID);
  localparam int KW     = idx_w(N_IN);
  localparam int A_W    = imax(OUT_W, W_W);
  localparam int B_W    = imax(W_W + X_W + 1, H_W + 1);
  localparam int PROD_W = prod_w(A_W, B_W);
  localparam int ACC_W  = acc_w(PROD_W, imax(N_IN, N_HID));
  localparam int VX_W   = W_W + X_W + 1;
  localparam logic signed [ACC_W-1:0] H_MAX_A = ACC_W'(2**H_W - 1);

  state_e                      state_q, state_d;
  logic [JW-1:0]               j_q, j_d;
  logic [KW-1:0]               k_q, k_d;
  logic [N_IN-1:0][X_W-1:0]    x_q, x_d;
  logic signed [OUT_W-1:0]     t_q, t_d, y_q, y_d, err_q, err_d;
  logic                        train_q, train_d, rdy_q;
  logic [N_HID-1:0][H_W-1:0]   h_q, h_d;
  logic [15:0]                 step_q, step_d;

  logic signed [W_W-1:0]       wt_q [NW];
  logic                        we;
  logic [AW-1:0]               waddr;
  logic signed [W_W-1:0]       wdata;

  logic [AW-1:0]               haddr, vaddr;
  logic signed [W_W-1:0]       w_rd, v_rd;
  logic [X_W-1:0]              xk;
  logic [H_W-1:0]              hj;
  logic signed [VX_W-1:0]      vx;

  logic                        mac_en, mac_clr;
  logic signed [A_W-1:0]       mac_a;
  logic signed [B_W-1:0]       mac_b;
  logic signed [ACC_W-1:0]     mac_sum, delta;
  logic [H_W-1:0]              hsat;
  logic signed [OUT_W-1:0]     ysat, errsat;
  logic signed [W_W-1:0]       wold, wnew;
  logic                        k_last, j_last;

  assign haddr  = AW'(int'(j_q) * N_IN + int'(k_q));
  assign vaddr  = AW'(VBASE + int'(j_q));
  assign w_rd   = wt_q[haddr];
  assign v_rd   = wt_q[vaddr];
  assign xk     = x_q[k_q];
  assign hj     = h_q[j_q];
  assign vx     = VX_W'(v_rd) * VX_W'(signed'({1'b0, xk}));
  assign k_last = (k_q == KW'(N_IN - 1));
  assign j_last = (j_q == JW'(N_HID - 1));

  mlp_mac #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .sum_o (mac_sum)
  );

  // MAC operand select; backward phases use clr so sum is the bare gradient product.
  always_comb begin
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    case (state_q)
      S_FWD_H: begin
        mac_en = 1'b1; mac_clr = (k_q == '0);
        mac_a  = A_W'(w_rd); mac_b = B_W'(signed'({1'b0, xk}));
      end
      S_FWD_O: begin
        mac_en = 1'b1; mac_clr = (j_q == '0);
        mac_a  = A_W'(v_rd); mac_b = B_W'(signed'({1'b0, hj}));
      end
      S_BWD_H: begin
        mac_en = 1'b1; mac_clr = 1'b1;
        mac_a  = A_W'(err_q); mac_b = B_W'(vx);
      end
      S_BWD_O: begin
        mac_en = 1'b1; mac_clr = 1'b1;
        mac_a  = A_W'(err_q); mac_b = B_W'(signed'({1'b0, hj}));
      end
      default: ;
    endcase
  end

  always_comb begin
    if (mac_sum[ACC_W-1])      hsat = '0;
    else if (mac_sum > H_MAX_A) hsat = '1;
    else                        hsat = mac_sum[H_W-1:0];
    ysat   = OUT_W'(sat(64'(mac_sum), OUT_W));
    errsat = OUT_W'(sat(64'(t_q) - 64'(y_q), OUT_W));
    delta  = (state_q == S_BWD_H) ? (mac_sum >>> (2*LR_SHIFT)) : (mac_sum >>> LR_SHIFT);
    wold   = (state_q == S_BWD_H) ? w_rd : v_rd;
`ifdef MLP_TRAIN_SEQ_SAT_EN
    wnew   = W_W'(sat(64'(wold) + 64'(delta), W_W));
`else
    wnew   = W_W'(64'(wold) + 64'(delta));
`endif
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    x_d     = x_q;
    t_d     = t_q;
    train_d = train_q;
    h_d     = h_q;
    y_d     = y_q;
    err_d   = err_q;
    step_d  = step_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (wld_valid_i) begin
          if (int'(wld_addr_i) < NW) begin
            we = 1'b1; waddr = wld_addr_i; wdata = wld_data_i;
          end
        end else if (in_valid_i && rdy_q) begin
          state_d = S_FWD_H; j_d = '0; k_d = '0;
          x_d = x_i; t_d = target_i; train_d = train_i;
        end
      end
      S_FWD_H, S_BWD_H: begin
        if (state_q == S_FWD_H && k_last) h_d[j_q] = hsat;
        // ReLU gate: neurons that did not fire keep their input weights.
        if (state_q == S_BWD_H && hj != '0) begin
          we = 1'b1; waddr = haddr; wdata = wnew;
        end
        if (k_last) begin
          k_d = '0;
          if (j_last) begin
            j_d = '0;
            state_d = (state_q == S_FWD_H) ? S_FWD_O : S_BWD_O;
          end else j_d = j_q + JW'(1);
        end else k_d = k_q + KW'(1);
      end
      S_FWD_O: begin
        if (j_last) begin
          y_d = ysat; j_d = '0; state_d = S_LOSS;
        end else j_d = j_q + JW'(1);
      end
      S_LOSS: begin
        if (train_q) begin
          err_d = errsat; step_d = step_q + 16'd1; state_d = S_BWD_H;
        end else begin
          err_d = '0; state_d = S_DONE;
        end
      end
      S_BWD_O: begin
        we = 1'b1; waddr = vaddr; wdata = wnew;
        if (j_last) begin
          j_d = '0; state_d = S_DONE;
        end else j_d = j_q + JW'(1);
      end
      S_DONE: if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      x_q     <= '0;
      t_q     <= '0;
      train_q <= 1'b0;
      h_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
      step_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      x_q     <= x_d;
      t_q     <= t_d;
      train_q <= train_d;
      h_q     <= h_d;
      y_q     <= y_d;
      err_q   <= err_d;
      step_q  <= step_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < N_HID; j++) begin
        for (int k = 0; k < N_IN; k++) wt_q[j*N_IN + k] <= W_W'(k + 1);
        wt_q[VBASE + j] <= W_W'(j + 1);
      end
    end else if (we) begin
      wt_q[waddr] <= wdata;
    end
  end

  assign in_ready_o  = rdy_q && (state_q == S_IDLE) && !wld_valid_i;
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign y_o         = y_q;
  assign err_o       = err_q;
  assign step_cnt_o  = step_q;

endmodule

// File: tb/tb_mlp_train_seq.sv
// Directed plus randomized checks of mlp_train_seq against an arithmetic reference model.
module tb_mlp_train_seq;
  localparam int N_IN = 4, N_HID = 2, NW = 10, VB = 8;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, train = 1'b0, out_ready = 1'b0, wld_valid = 1'b0;
  logic [15:0] x = '0;
  logic signed [18:0] target = '0;
  logic [3:0] wld_addr = '0;
  logic signed [7:0] wld_data = '0;
  logic in_ready, out_valid, busy;
  logic signed [18:0] y, err;
  logic [15:0] step;

  int vectors = 0, miscompares = 0;
  longint mw[NW];
  logic [15:0] msteps;

  always #5 clk = ~clk;

  mlp_train_seq dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .x_i(x),
    .target_i(target), .train_i(train), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y), .err_o(err), .wld_valid_i(wld_valid), .wld_addr_i(wld_addr),
    .wld_data_i(wld_data), .busy_o(busy), .step_cnt_o(step)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic longint wupd(input longint v);
`ifdef MLP_TRAIN_SEQ_SAT_EN
    return clampl(v, -128, 127);
`else
    return longint'(byte'(v));
`endif
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N_HID; j++) begin
      for (int k = 0; k < N_IN; k++) mw[j*N_IN + k] = k + 1;
      mw[VB + j] = j + 1;
    end
    msteps = 0;
  endtask

  task automatic model_sample(input logic [15:0] xv, input longint tv, input logic tr,
                              output logic signed [63:0] ey, output logic signed [63:0] ee);
    longint xs[N_IN], h[N_HID], acc, yy, e;
    for (int k = 0; k < N_IN; k++) xs[k] = longint'(xv[k*4 +: 4]);
    for (int j = 0; j < N_HID; j++) begin
      acc = 0;
      for (int k = 0; k < N_IN; k++) acc += mw[j*N_IN + k] * xs[k];
      h[j] = clampl(acc, 0, 1023);
    end
    yy = 0;
    for (int j = 0; j < N_HID; j++) yy += mw[VB + j] * h[j];
    yy = clampl(yy, -262144, 262143);
    e = tr ? clampl(tv - yy, -262144, 262143) : 0;
    if (tr) begin
      for (int j = 0; j < N_HID; j++)
        if (h[j] > 0)
          for (int k = 0; k < N_IN; k++)
            mw[j*N_IN + k] = wupd(mw[j*N_IN + k] + ((e * mw[VB + j] * xs[k]) >>> 8));
      for (int j = 0; j < N_HID; j++) mw[VB + j] = wupd(mw[VB + j] + ((e * h[j]) >>> 4));
      msteps = msteps + 16'd1;
    end
    ey = yy;
    ee = e;
  endtask

  task automatic send(input logic [15:0] xv, input logic signed [18:0] tv, input logic tr,
                      input int hold, input logic dw, input logic [3:0] wa, input logic signed [7:0] wd);
    logic signed [63:0] ey, ee;
    int cyc;
    @(negedge clk);
    x = xv; target = tv; train = tr; in_valid = 1'b1;
    if (dw) begin
      wld_valid = 1'b1; wld_addr = wa; wld_data = wd;
      #1 chk("wld_blocks_ready", in_ready, 0);
      if (wa < NW) mw[wa] = wd;
      @(negedge clk);
      wld_valid = 1'b0;
    end
    model_sample(xv, longint'(tv), tr, ey, ee);
    #1 cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); #1 cyc++; end
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 60);
    chk("latency", cyc, tr ? 22 : 12);
    chk("y", y, ey);
    chk("err", err, ee);
    chk("step", step, msteps);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("held_valid", out_valid, 1);
      chk("held_y", y, ey);
      chk("held_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle", busy, 0);
  endtask

  initial begin
    int ov;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_err", err, 0);
    chk("rst_step", step, 0);
    rst = 1'b0;
    #1 chk("ready_first_cycle", in_ready, 0);
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    send(16'h1111, 19'sd0, 1'b0, 0, 1'b0, 4'd0, 8'sd0);
    chk("infer_y30", y, 30);
    chk("infer_err0", err, 0);
    send(16'h0001, 19'sd0, 1'b1, 0, 1'b0, 4'd0, 8'sd0);
    chk("train_y3", y, 3);
    chk("train_err_m3", err, -3);
    chk("train_step1", step, 1);
    send(16'h0010, 19'sd0, 1'b0, 5, 1'b0, 4'd0, 8'sd0);
    chk("v_after_update", y, 2);

    send(16'hFFFF, 19'sd262143, 1'b1, 0, 1'b1, 4'd8, 8'sd127);
    send(16'h1111, 19'sd0, 1'b0, 0, 1'b0, 4'd0, 8'sd0);
    send(16'h2222, 19'sd5, 1'b0, 1, 1'b1, 4'd12, 8'sd99);

    for (int n = 0; n < 24; n++)
      send(16'($urandom), 19'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 8'($urandom));

    @(negedge clk);
    x = 16'h1234; target = 19'sd1000; train = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_in_bwd", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    rst = 1'b0;
    model_reset();
    ov = 0;
    repeat (30) begin @(negedge clk); if (out_valid) ov++; end
    chk("no_valid_after_abort", ov, 0);
    chk("step_cleared", step, 0);
    send(16'h1111, 19'sd0, 1'b0, 0, 1'b0, 4'd0, 8'sd0);
    chk("weights_restored", y, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
